// File: rtl/ads7830_i2c_master.sv
// rtl/ads7830_i2c_master.sv - Avalon-MM read request to ADS7830 I2C single-channel conversion bridge
module ads7830_i2c_master #(
    parameter int          SYS_CLK_FREQ_HZ = 25000000,
    parameter int          I2C_FREQ_HZ     = 100000,
    parameter logic [6:0]  DEV_ADDR        = 7'h48,
    parameter logic [1:0]  PD_MODE         = 2'b01
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic [2:0] address,
    input  logic       read,
    output logic [7:0] readdata,
    output logic       readdatavalid,
    output logic       scl_oe_o,
    output logic       sda_oe_o,
    input  logic       sda_i,
    output logic       err_o,
    output logic       busy_o
);
    localparam int QDIV = SYS_CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int QW   = $clog2(QDIV);
    localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, WR_ADDR, WR_CMD, RSTART, RD_ADDR, RD_DATA, STOP, DONE, BUF
    } state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] qcnt;
    logic [1:0]    qtr;
    logic [3:0]    bitn;
    logic [2:0]    addr_q;
    logic [7:0]    rx_q;
    logic          nack_q;
    logic          scl_nxt, sda_nxt;
    logic [7:0]    tx_byte;
    logic          counting, tick, step_end, byte_state, wr_byte, sample;

    // DONE is a single cycle, so the quarter counter is held cleared there as in IDLE
    assign counting   = (state != IDLE) && (state != DONE);
    assign tick       = counting && (qcnt == QMAX);
    assign step_end   = tick && (qtr == 2'd3);
    assign byte_state = (state == WR_ADDR) || (state == WR_CMD) || (state == RD_ADDR) || (state == RD_DATA);
    assign wr_byte    = (state == WR_ADDR) || (state == WR_CMD) || (state == RD_ADDR);
    assign sample     = byte_state && (qtr == 2'd3) && (qcnt == '0);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            qcnt     <= '0;
            qtr      <= 2'd0;
            bitn     <= 4'd0;
            addr_q   <= 3'd0;
            rx_q     <= 8'h00;
            nack_q   <= 1'b0;
            readdata <= 8'h00;
            scl_oe_o <= 1'b0;
            sda_oe_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            scl_oe_o <= scl_nxt;
            sda_oe_o <= sda_nxt;
            if (!counting) begin
                qcnt <= '0;
                qtr  <= 2'd0;
                bitn <= 4'd0;
            end else begin
                qcnt <= tick ? '0 : qcnt + 1'b1;
                if (tick)
                    qtr <= qtr + 2'd1;
                if (step_end && byte_state)
                    bitn <= (bitn == 4'd8) ? 4'd0 : bitn + 4'd1;
            end
            if (state == IDLE) begin
                nack_q <= 1'b0;
                if (read)
                    addr_q <= address;
            end
            if (sample && wr_byte && (bitn == 4'd8) && sda_i)
                nack_q <= 1'b1;
            if (sample && (state == RD_DATA) && (bitn != 4'd8))
                rx_q <= {rx_q[6:0], sda_i};
            if ((state == STOP) && step_end)
                readdata <= nack_q ? 8'h00 : rx_q;
        end
    end

    always_comb begin
        state_nxt = state;
        scl_nxt   = 1'b0;
        sda_nxt   = 1'b0;
        tx_byte   = 8'hFF;
        case (state)
            IDLE: begin
                if (read)
                    state_nxt = START;
            end
            START: begin
                sda_nxt = 1'b1;
                scl_nxt = qtr[1];
                if (step_end)
                    state_nxt = WR_ADDR;
            end
            WR_ADDR, WR_CMD, RD_ADDR, RD_DATA: begin
                case (state)
                    WR_ADDR: tx_byte = {DEV_ADDR, 1'b0};
                    WR_CMD:  tx_byte = {1'b1, addr_q, PD_MODE, 2'b00};
                    RD_ADDR: tx_byte = {DEV_ADDR, 1'b1};
                    default: tx_byte = 8'hFF;
                endcase
                scl_nxt = ~qtr[1];
                // ninth bit always released: slave ACK slot, or master NACK after the data byte
                sda_nxt = (bitn != 4'd8) && !tx_byte[~bitn[2:0]];
                if (step_end && (bitn == 4'd8)) begin
                    if (nack_q)
                        state_nxt = STOP;
                    else begin
                        case (state)
                            WR_ADDR: state_nxt = WR_CMD;
                            WR_CMD:  state_nxt = RSTART;
                            RD_ADDR: state_nxt = RD_DATA;
                            default: state_nxt = STOP;
                        endcase
                    end
                end
            end
            RSTART: begin
                scl_nxt = (qtr == 2'd0) || (qtr == 2'd3);
                sda_nxt = qtr[1];
                if (step_end)
                    state_nxt = RD_ADDR;
            end
            STOP: begin
                scl_nxt = (qtr == 2'd0);
                sda_nxt = (qtr != 2'd3);
                if (step_end)
                    state_nxt = DONE;
            end
            DONE: begin
                state_nxt = BUF;
            end
            BUF: begin
                if (step_end)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign readdatavalid = (state == DONE);
    assign err_o         = (state == DONE) && nack_q;
    assign busy_o        = (state != IDLE);

endmodule
